// File: rtl/i2s_codec_ep.sv
// I2S target endpoint (Philips format, MSB first).
// Captures the controller's SD line into stereo frames and drives stereo frames back on SD.
module i2s_codec_ep #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic [1:0]                wlen_i,
    input  logic                      sck_i,
    input  logic                      ws_i,
    input  logic                      sd_i,
    output logic                      sd_o,
    input  logic                      tx_valid_i,
    output logic                      tx_ready_o,
    input  logic [2*DATA_WIDTH-1:0]   tx_data_i,
    output logic                      rx_valid_o,
    input  logic                      rx_ready_i,
    output logic [2*DATA_WIDTH-1:0]   rx_data_o,
    output logic                      locked_o,
    output logic                      tx_udf_o,
    output logic                      rx_ovf_o
);
    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] MSB = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, ws_sync, sd_sync;
    logic                   sck_d, sck_s, ws_s, sd_s;
    logic                   rise, fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
            ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
            sd_sync  <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            sck_d    <= sck_s;
        end
    end

    assign sck_s = sck_sync[SYNC_STAGES-1];
    assign ws_s  = ws_sync[SYNC_STAGES-1];
    assign sd_s  = sd_sync[SYNC_STAGES-1];
    assign rise  = sck_s & ~sck_d;
    assign fall  = ~sck_s & sck_d;

    logic [5:0]    bcnt, wbits;
    logic          ws_prev, in_w, trans, xfer, done;
    logic [DW-1:0] shift, mask, word, left_w, chan;

    // mask selects the bit at slot position bcnt; it empties past DW
    assign wbits = {1'b0, wlen_i, 3'b000} + 6'd8;
    assign mask  = MSB >> bcnt;
    assign in_w  = bcnt < wbits;
    assign word  = (in_w && sd_s) ? (shift | mask) : shift;
    assign trans = rise & (ws_s ^ ws_prev);
    assign xfer  = trans & ws_prev & en_i & (state != IDLE);
    assign done  = trans & ws_prev & en_i & (state == RUN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bcnt    <= '0;
            ws_prev <= 1'b0;
            shift   <= '0;
            left_w  <= '0;
        end else if (rise) begin
            if (trans) begin
                bcnt    <= '0;
                ws_prev <= ws_s;
                shift   <= '0;
                if (!ws_prev && state == RUN) left_w <= word;
            end else begin
                shift <= word;
                if (bcnt != 6'h3f) bcnt <= bcnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        locked_o  = 1'b0;
        case (state)
            IDLE: if (en_i) state_nxt = SYNC;
            SYNC: begin
                if (!en_i)     state_nxt = IDLE;
                else if (xfer) state_nxt = RUN;
            end
            RUN: begin
                locked_o = 1'b1;
                if (!en_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    logic [2*DW-1:0] stg, act;
    logic            stg_full, accept;

    assign tx_ready_o = en_i & ~stg_full;
    assign accept     = tx_valid_i & tx_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i) begin
            stg      <= '0;
            stg_full <= 1'b0;
            act      <= '0;
            tx_udf_o <= 1'b0;
        end else begin
            tx_udf_o <= 1'b0;
            if (accept) stg <= tx_data_i;
            if (xfer) begin
                act      <= stg_full ? stg : '0;
                tx_udf_o <= ~stg_full;
            end
            if (accept)    stg_full <= 1'b1;
            else if (xfer) stg_full <= 1'b0;
        end
    end

    assign chan = ws_prev ? act[DW-1:0] : act[2*DW-1:DW];

    always_ff @(posedge clk_i) begin
        if (rst_i || !en_i)
            sd_o <= 1'b0;
        else if (fall && state == RUN)
            sd_o <= in_w & (|(chan & mask));
    end

    // a consume coinciding with completion is not an overflow
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
            rx_ovf_o   <= 1'b0;
        end else begin
            rx_ovf_o <= 1'b0;
            if (!en_i) begin
                rx_valid_o <= 1'b0;
            end else if (done) begin
                rx_data_o  <= {left_w, word};
                rx_valid_o <= 1'b1;
                rx_ovf_o   <= rx_valid_o & ~rx_ready_i;
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
        end
    end
endmodule
